// File: rtl/sockit_spi_pkg.sv
// Shared helpers for the sockit SPI FIFOs.
//   lvl_width : bits needed to hold an occupancy count of 0..depth
//   ptr_inc   : pointer increment with wrap at depth-1 (any depth, not only 2^n)
package sockit_spi_pkg;

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sockit_spi_fifo_mem.sv
// DW x DEPTH register array: one synchronous write port, one asynchronous read port.
// Kept separate so it can be replaced by a vendor RAM. Contents are not reset.
//   clk : write clock
//   we  : write enable
//   wa  : write address
//   wd  : write data
//   ra  : read address
//   rd  : read data (combinational from ra)
module sockit_spi_fifo_mem #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/sockit_spi_fifo.sv
// Single-clock FIFO with valid/ready on both sides, synchronous clear,
// occupancy level, almost-full/almost-empty flags and a peak-level watermark.
//   clk, rst         : clock, asynchronous active-high reset
//   clr              : synchronous clear of contents and watermark
//   fi_vld/fi_dat/fi_rdy : input handshake (fi_rdy = not full)
//   fo_vld/fo_dat/fo_rdy : output handshake (fo_vld = not empty, fo_dat = head)
//   alf_thr, ale_thr : almost-full / almost-empty thresholds
//   lvl              : current occupancy 0..DEPTH
//   alf, ale         : lvl >= alf_thr, lvl <= ale_thr
//   pk_lvl           : highest lvl since reset/clear
module sockit_spi_fifo
    import sockit_spi_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = lvl_width(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          fi_vld,
    input  logic [DW-1:0] fi_dat,
    output logic          fi_rdy,
    output logic          fo_vld,
    output logic [DW-1:0] fo_dat,
    input  logic          fo_rdy,
    input  logic [CW-1:0] alf_thr,
    input  logic [CW-1:0] ale_thr,
    output logic [CW-1:0] lvl,
    output logic          alf,
    output logic          ale,
    output logic [CW-1:0] pk_lvl
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] lvl_nxt;
    logic          push;
    logic          pop;

    // Handshake qualifiers depend only on registered lvl, so there is no
    // combinational path from fi_vld to fo_vld or from fo_rdy to fi_rdy.
    assign fi_rdy = (lvl != LVL_FULL);
    assign fo_vld = (lvl != '0);
    assign push   = fi_vld & fi_rdy;
    assign pop    = fo_vld & fo_rdy;

    assign alf = (lvl >= alf_thr);
    assign ale = (lvl <= ale_thr);

    always_comb begin
        lvl_nxt = lvl;
        if (clr)
            lvl_nxt = '0;
        else if (push && !pop)
            lvl_nxt = lvl + CW'(1);
        else if (pop && !push)
            lvl_nxt = lvl - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            pk_lvl <= '0;
        end else begin
            lvl <= lvl_nxt;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                pk_lvl <= '0;
            end else begin
                if (push) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
                if (pop)  rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
                if (lvl_nxt > pk_lvl) pk_lvl <= lvl_nxt;
            end
        end
    end

    // A write during clr lands in an entry that the reset pointers make
    // unreachable until it is overwritten, so it needs no extra qualification.
    sockit_spi_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk (clk),
        .we  (push),
        .wa  (wr_ptr),
        .wd  (fi_dat),
        .ra  (rd_ptr),
        .rd  (fo_dat)
    );

endmodule

// File: tb/tb_sockit_spi_fifo.sv
// Directed bench for sockit_spi_fifo, DEPTH=5, DW=8.
module tb_sockit_spi_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          fi_vld;
    logic [DW-1:0] fi_dat;
    logic          fi_rdy;
    logic          fo_vld;
    logic [DW-1:0] fo_dat;
    logic          fo_rdy;
    logic [CW-1:0] alf_thr;
    logic [CW-1:0] ale_thr;
    logic [CW-1:0] lvl;
    logic          alf;
    logic          ale;
    logic [CW-1:0] pk_lvl;

    int tests = 0;
    int fails = 0;

    sockit_spi_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .fi_vld  (fi_vld),
        .fi_dat  (fi_dat),
        .fi_rdy  (fi_rdy),
        .fo_vld  (fo_vld),
        .fo_dat  (fo_dat),
        .fo_rdy  (fo_rdy),
        .alf_thr (alf_thr),
        .ale_thr (ale_thr),
        .lvl     (lvl),
        .alf     (alf),
        .ale     (ale),
        .pk_lvl  (pk_lvl)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge; checks happen there too.
    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        fi_vld = v;
        fi_dat = d;
        fo_rdy = r;
        clr    = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alf_thr = 3'd0;
        ale_thr = 3'd1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        tests++; if (fi_rdy !== 1'b1) begin fails++; $display("FAIL reset_fi_rdy got %b want 1", fi_rdy); end
        tests++; if (fo_vld !== 1'b0) begin fails++; $display("FAIL reset_fo_vld got %b want 0", fo_vld); end
        tests++; if (lvl !== 3'd0) begin fails++; $display("FAIL reset_lvl got %0d want 0", lvl); end
        tests++; if (pk_lvl !== 3'd0) begin fails++; $display("FAIL reset_pk got %0d want 0", pk_lvl); end
        tests++; if (ale !== 1'b1) begin fails++; $display("FAIL reset_ale got %b want 1", ale); end
        tests++; if (alf !== 1'b1) begin fails++; $display("FAIL reset_alf_thr0 got %b want 1", alf); end
        alf_thr = 3'd3;
        #1;
        tests++; if (alf !== 1'b0) begin fails++; $display("FAIL reset_alf_thr3 got %b want 0", alf); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
            tests++; if (lvl !== 3'(i)) begin fails++; $display("FAIL fill_lvl got %0d want %0d", lvl, i); end
        end
        tests++; if (fi_rdy !== 1'b0) begin fails++; $display("FAIL full_fi_rdy got %b want 0", fi_rdy); end
        drive(1'b1, 8'h06, 1'b0, 1'b0);
        tick();
        tests++; if (lvl !== 3'd5) begin fails++; $display("FAIL held_push_lvl got %0d want 5", lvl); end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tests++; if (fo_vld !== 1'b1 || fo_dat !== 8'(i)) begin
                fails++; $display("FAIL drain_data got vld=%b dat=%h want vld=1 dat=%h", fo_vld, fo_dat, 8'(i));
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (fo_vld !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", fo_vld); end
        tests++; if (pk_lvl !== 3'd5) begin fails++; $display("FAIL drain_pk got %0d want 5", pk_lvl); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
            tests++; if (fo_dat !== 8'(8'h10 + i)) begin
                fails++; $display("FAIL wrap_data got %h want %h", fo_dat, 8'(8'h10 + i));
            end
            tick();
            tests++; if (lvl !== 3'd2) begin fails++; $display("FAIL wrap_lvl got %0d want 2", lvl); end
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (fo_dat !== 8'h1C) begin fails++; $display("FAIL wrap_tail0 got %h want 1c", fo_dat); end
        tick();
        tests++; if (fo_dat !== 8'h1D) begin fails++; $display("FAIL wrap_tail1 got %h want 1d", fo_dat); end
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (fo_vld !== 1'b0) begin fails++; $display("FAIL wrap_empty got %b want 0", fo_vld); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        tests++; if (fo_dat !== 8'h20) begin fails++; $display("FAIL fpp_head got %h want 20", fo_dat); end
        tick();
        tests++; if (lvl !== 3'd4) begin fails++; $display("FAIL fpp_lvl got %0d want 4", lvl); end
        tests++; if (fi_rdy !== 1'b1) begin fails++; $display("FAIL fpp_fi_rdy got %b want 1", fi_rdy); end
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tests++; if (fo_dat !== 8'(8'h20 + i)) begin
                fails++; $display("FAIL fpp_drain got %h want %h", fo_dat, 8'(8'h20 + i));
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (fo_vld !== 1'b0) begin fails++; $display("FAIL fpp_empty got %b want 0", fo_vld); end
    endtask

    task automatic test_thresholds();
        logic [4:0] alf_exp;
        logic [4:0] ale_exp;
        alf_exp = 5'b11000;   // bit n = expected alf at lvl n, alf_thr=3
        ale_exp = 5'b00011;   // bit n = expected ale at lvl n, ale_thr=1
        alf_thr = 3'd3;
        ale_thr = 3'd1;
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            tests++; if (alf !== alf_exp[n] || ale !== ale_exp[n]) begin
                fails++; $display("FAIL thr_flags lvl=%0d got alf=%b ale=%b want alf=%b ale=%b", n, alf, ale, alf_exp[n], ale_exp[n]);
            end
            drive(1'b1, 8'(8'h50 + n), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        alf_thr = 3'd0;
        ale_thr = 3'd5;
        #1;
        tests++; if (alf !== 1'b1 || ale !== 1'b1) begin
            fails++; $display("FAIL thr_extreme got alf=%b ale=%b want alf=1 ale=1", alf, ale);
        end
        alf_thr = 3'd3;
        ale_thr = 3'd1;
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_clr();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        tests++; if (pk_lvl !== 3'd4 || lvl !== 3'd1) begin
            fails++; $display("FAIL clr_pre got pk=%0d lvl=%0d want pk=4 lvl=1", pk_lvl, lvl);
        end
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (lvl !== 3'd0 || pk_lvl !== 3'd0 || fo_vld !== 1'b0) begin
            fails++; $display("FAIL clr_post got lvl=%0d pk=%0d vld=%b want 0 0 0", lvl, pk_lvl, fo_vld);
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (fo_dat !== 8'h55 || lvl !== 3'd1) begin
            fails++; $display("FAIL clr_next got dat=%h lvl=%0d want 55 1", fo_dat, lvl);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            tick();
        end
        tests++; if (lvl !== 3'd3) begin fails++; $display("FAIL arst_pre_lvl got %0d want 3", lvl); end
        rst = 1'b1;
        #1;
        tests++; if (fo_vld !== 1'b0 || fi_rdy !== 1'b1 || lvl !== 3'd0 || pk_lvl !== 3'd0) begin
            fails++; $display("FAIL arst_now got vld=%b rdy=%b lvl=%0d pk=%0d want 0 1 0 0", fo_vld, fi_rdy, lvl, pk_lvl);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'hA5, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (fo_vld !== 1'b1 || fo_dat !== 8'hA5) begin
            fails++; $display("FAIL arst_a5 got vld=%b dat=%h want 1 a5", fo_vld, fo_dat);
        end
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (lvl !== 3'd0) begin fails++; $display("FAIL arst_a5_pop got lvl %0d want 0", lvl); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_push_pop();
        test_thresholds();
        test_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
